// File: rtl/switch_entry_fifo_if.sv
// Consumer-side stream of switch_entry_fifo: head entry, valid/ready handshake
// and occupancy status for display.
interface switch_entry_fifo_if #(
  parameter int unsigned AW = 2
);
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready;
  logic [AW:0] count;
  logic        full;
  logic        overflow;

  modport master (
    output data_out, data_valid, count, full, overflow,
    input  data_ready
  );

  modport slave (
    input  data_out, data_valid, count, full, overflow,
    output data_ready
  );
endinterface

// File: rtl/switch_entry_fifo.sv
// Debounced switch-entry capture into a small FIFO drained over valid/ready.
// Optional sticky drop flag enabled by defining SWITCH_ENTRY_OVERFLOW_EN.

module switch_entry_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic Reset,
  input  logic raw,
  output logic pulse
);
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} db_state_t;

  db_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    sync_q;
  logic          sync;

  assign sync = sync_q[1];

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      sync_q <= '0;
      state  <= RELEASED;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      state  <= state_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse     = 1'b0;
    unique case (state)
      RELEASED: begin
        if (sync) begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = '0;
        end
      end
      PRESS_CHK: begin
        if (!sync) begin
          state_nxt = RELEASED;
        end else if (cnt == LAST) begin
          state_nxt = PRESSED;
          pulse     = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_nxt = RELEASE_CHK;
          cnt_nxt   = '0;
        end
      end
      RELEASE_CHK: begin
        if (sync) begin
          state_nxt = PRESSED;
        end else if (cnt == LAST) begin
          state_nxt = RELEASED;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = RELEASED;
    endcase
  end
endmodule

module switch_entry_fifo #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned AW              = 2
) (
  input  logic                   clock,
  input  logic                   Reset,
  input  logic [7:0]             sw_data,
  input  logic                   btn_enter,
  input  logic                   btn_clear,
  switch_entry_fifo_if.master    deq
);
  logic          enter_pulse, clear_pulse;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count_q;
  logic          full, pop, push;

  switch_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clock (clock),
    .Reset (Reset),
    .raw   (btn_enter),
    .pulse (enter_pulse)
  );

  switch_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clock (clock),
    .Reset (Reset),
    .raw   (btn_clear),
    .pulse (clear_pulse)
  );

  assign full           = (count_q == (AW+1)'(DEPTH));
  assign deq.full       = full;
  assign deq.count      = count_q;
  assign deq.data_valid = (count_q != '0);
  assign deq.data_out   = mem[rd_ptr];

  // When full, a same-cycle pop frees the slot the push writes into.
  assign pop  = deq.data_valid && deq.data_ready;
  assign push = enter_pulse && (!full || pop);

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear_pulse) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= sw_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef SWITCH_ENTRY_OVERFLOW_EN
  logic overflow_q;
  logic drop;

  assign drop = enter_pulse && full && !pop;

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset)            overflow_q <= 1'b0;
    else if (clear_pulse) overflow_q <= 1'b0;
    else if (drop)        overflow_q <= 1'b1;
  end

  assign deq.overflow = overflow_q;
`else
  assign deq.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_switch_entry_fifo.sv
// Directed bench for switch_entry_fifo with DEBOUNCE_CYCLES=4, DEPTH=4.
module tb_switch_entry_fifo;
`ifdef SWITCH_ENTRY_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] sw_data = '0;
  logic       btn_enter = 1'b0;
  logic       btn_clear = 1'b0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  switch_entry_fifo_if #(.AW(2)) deq_if ();

  switch_entry_fifo #(.DEBOUNCE_CYCLES(4), .DEPTH(4), .AW(2)) dut (
    .clock     (clock),
    .Reset     (Reset),
    .sw_data   (sw_data),
    .btn_enter (btn_enter),
    .btn_clear (btn_clear),
    .deq       (deq_if)
  );

  always #5 clock = ~clock;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push lands at the 7th edge after the press; release fully settles within 8 cycles.
  task automatic press_enter(input logic [7:0] v);
    sw_data   = v;
    btn_enter = 1'b1;
    step(8);
    btn_enter = 1'b0;
    step(8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    deq_if.data_ready = 1'b0;
    step(3);
    check("rst_count", deq_if.count, 0);
    check("rst_valid", deq_if.data_valid, 0);
    check("rst_data",  deq_if.data_out, 0);
    check("rst_full",  deq_if.full, 0);
    check("rst_ovf",   deq_if.overflow, 0);
    Reset = 1'b0;
    step(2);

    // Clean press held 20 cycles
    sw_data   = 8'h3C;
    btn_enter = 1'b1;
    step(6);
    check("t2_pre_push", deq_if.count, 0);
    step(1);
    check("t2_count", deq_if.count, 1);
    check("t2_data",  deq_if.data_out, 8'h3C);
    check("t2_valid", deq_if.data_valid, 1);
    step(13);
    check("t2_single", deq_if.count, 1);
    btn_enter = 1'b0;
    step(10);

    // Bounce then stable hold
    sw_data   = 8'hA5;
    btn_enter = 1'b1; step(1);
    btn_enter = 1'b0; step(1);
    btn_enter = 1'b1; step(1);
    btn_enter = 1'b0; step(1);
    btn_enter = 1'b1;
    step(6);
    check("t3_no_bounce_push", deq_if.count, 1);
    step(1);
    check("t3_push", deq_if.count, 2);
    step(15);
    check("t3_single", deq_if.count, 2);
    btn_enter = 1'b0;
    step(10);
    deq_if.data_ready = 1'b1;
    check("t3_rd0", deq_if.data_out, 8'h3C);
    step(1);
    check("t3_rd1", deq_if.data_out, 8'hA5);
    step(1);
    check("t3_empty", deq_if.data_valid, 0);
    step(2);
    check("t3_idle_ready", deq_if.count, 0);
    deq_if.data_ready = 1'b0;

    // Fill, drop on full, drain
    press_enter(8'h11);
    press_enter(8'h22);
    press_enter(8'h33);
    press_enter(8'h44);
    check("t4_full",  deq_if.full, 1);
    check("t4_count", deq_if.count, 4);
    press_enter(8'h55);
    check("t4_drop_count", deq_if.count, 4);
    check("t4_ovf", deq_if.overflow, OVF_EN);
    deq_if.data_ready = 1'b1;
    check("t4_rd0", deq_if.data_out, 8'h11);
    step(1);
    check("t4_rd1", deq_if.data_out, 8'h22);
    step(1);
    check("t4_rd2", deq_if.data_out, 8'h33);
    step(1);
    check("t4_rd3", deq_if.data_out, 8'h44);
    check("t4_notfull", deq_if.full, 0);
    step(1);
    check("t4_empty", deq_if.data_valid, 0);
    deq_if.data_ready = 1'b0;

    // Full with pop in the push pulse cycle
    press_enter(8'h11);
    press_enter(8'h22);
    press_enter(8'h33);
    press_enter(8'h44);
    sw_data   = 8'h55;
    btn_enter = 1'b1;
    step(6);
    deq_if.data_ready = 1'b1;
    check("t5_pre_count", deq_if.count, 4);
    check("t5_pre_head",  deq_if.data_out, 8'h11);
    step(1);
    deq_if.data_ready = 1'b0;
    check("t5_count", deq_if.count, 4);
    check("t5_head",  deq_if.data_out, 8'h22);
    btn_enter = 1'b0;
    step(8);
    check("t5_ovf_sticky", deq_if.overflow, OVF_EN);
    deq_if.data_ready = 1'b1;
    check("t5_rd0", deq_if.data_out, 8'h22);
    step(1);
    check("t5_rd1", deq_if.data_out, 8'h33);
    step(1);
    check("t5_rd2", deq_if.data_out, 8'h44);
    step(1);
    check("t5_rd3", deq_if.data_out, 8'h55);
    step(1);
    check("t5_empty", deq_if.data_valid, 0);
    deq_if.data_ready = 1'b0;

    // Clear wins over same-cycle push and pop
    press_enter(8'h01);
    press_enter(8'h02);
    press_enter(8'h03);
    check("t6_pre", deq_if.count, 3);
    sw_data   = 8'h66;
    btn_enter = 1'b1;
    btn_clear = 1'b1;
    step(6);
    deq_if.data_ready = 1'b1;
    step(1);
    deq_if.data_ready = 1'b0;
    check("t6_count", deq_if.count, 0);
    check("t6_valid", deq_if.data_valid, 0);
    check("t6_ovf",   deq_if.overflow, 0);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    step(10);
    check("t6_stays_clear", deq_if.count, 0);

    // Asynchronous reset mid-debounce with data queued
    press_enter(8'h77);
    check("t1_pre", deq_if.count, 1);
    btn_enter = 1'b1;
    step(3);
    #2;
    Reset = 1'b1;
    #1;
    check("t1_async_count", deq_if.count, 0);
    check("t1_async_valid", deq_if.data_valid, 0);
    check("t1_async_data",  deq_if.data_out, 0);
    check("t1_async_full",  deq_if.full, 0);
    check("t1_async_ovf",   deq_if.overflow, 0);
    btn_enter = 1'b0;
    step(2);
    Reset = 1'b0;
    step(10);
    check("t1_post_count", deq_if.count, 0);
    check("t1_post_valid", deq_if.data_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
